freq_counter_multi: RTL and testbench

- Parametrised multi-channel frequency meter in the slowclock domain; replaces the single asynchronous DUT-clock counter.
- Counts edges of NUM_CH asynchronous inputs (DUT clock, trigger, ADC sample clock, ...) over a programmable gate window.
- Reports a saturating count per channel with valid/overflow flags.
- Supports continuous or single-shot operation under register control from usb_interface.

---
 rtl/freq_counter_pkg.sv | 28 ++
 rtl/freq_counter_multi_chan.sv | 74 +++++++
 rtl/freq_counter_multi.sv | 127 ++++++++++++
 tb/tb_freq_counter_multi.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared mode encodings, gate FSM states and helpers for the frequency meter.
package freq_counter_pkg;

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_CONT   = 2'b01;
   localparam logic [1:0] MODE_SINGLE = 2'b10;

   // Shortest gate window; smaller programmed values are raised to this.
   localparam int unsigned GATE_MIN = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } gate_state_t;

   // True for the two modes that keep a window running; 2'b11 behaves as off.
   function automatic logic mode_is_run(input logic [1:0] mode);
      logic run;
      case (mode)
         MODE_CONT:   run = 1'b1;
         MODE_SINGLE: run = 1'b1;
         MODE_OFF:    run = 1'b0;
         default:     run = 1'b0;
      endcase
      return run;
   endfunction

endpackage

// File: rtl/freq_counter_multi_chan.sv
// One measured input: synchroniser, edge detector and saturating edge counter.
// count_c/ovf_c present the window total including an edge detected this cycle,
// so the top level can latch them on the boundary while the counter restarts.
module freq_chan
   import freq_counter_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             slowclock,
   input  logic             reset,
   input  logic             meas,
   input  logic             edge_sel,
   input  logic             clear,
   input  logic             capture,
   output logic [CNT_W-1:0] count_c,
   output logic             ovf_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_q;
   logic                   edge_c;
   logic                   sat_c;

   // Synchroniser chain followed by a history flop for edge detection.
   always_ff @(posedge slowclock) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], meas};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge detect and saturating increment of the running window count.
   always_comb begin
      edge_c  = 1'b0;
      sat_c   = 1'b0;
      count_c = cnt_q;
      ovf_c   = ovf_q;
      if (edge_sel) begin
         edge_c = sync_q[SYNC_STAGES-1] ^ hist_q;
      end else begin
         edge_c = sync_q[SYNC_STAGES-1] & ~hist_q;
      end
      sat_c = edge_c && (cnt_q == CNT_MAX);
      if (sat_c) begin
         count_c = CNT_MAX;
      end else begin
         count_c = cnt_q + CNT_W'(edge_c);
      end
      ovf_c = ovf_q | sat_c;
   end

   // Window counter: held at zero while idle, restarts on every boundary.
   always_ff @(posedge slowclock) begin
      if (reset) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear || capture) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= count_c;
         ovf_q <= ovf_c;
      end
   end

endmodule

// File: rtl/freq_counter_multi.sv
// Multi-channel frequency meter: gate FSM, gate counter and result registers.
// Channel n result sits in freq_o[n*CNT_W +: CNT_W].
module freq_counter_multi
   import freq_counter_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned GATE_W      = 26,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    slowclock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       meas_i,
   input  logic [1:0]              mode_i,
   input  logic [NUM_CH-1:0]       edge_sel_i,
   input  logic [GATE_W-1:0]       gate_period_i,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    valid_o,
   output logic [NUM_CH*CNT_W-1:0] freq_o,
   output logic [NUM_CH-1:0]       ovf_o
);

   gate_state_t state_q;
   gate_state_t state_nxt;

   logic [GATE_W-1:0]            gate_cnt_q;
   logic [GATE_W-1:0]            gate_cnt_nxt;
   logic [GATE_W-1:0]            gate_q;
   logic [NUM_CH-1:0]            edge_sel_q;
   logic [GATE_W-1:0]            gate_eff_c;
   logic [GATE_W-1:0]            gate_last_c;
   logic                         mode_run_c;
   logic                         load_cfg_c;
   logic                         done_c;
   logic                         chan_clear_c;
   logic [NUM_CH-1:0][CNT_W-1:0] chan_count_c;
   logic [NUM_CH-1:0]            chan_ovf_c;

   assign gate_eff_c  = (gate_period_i < GATE_W'(GATE_MIN)) ? GATE_W'(GATE_MIN) : gate_period_i;
   assign gate_last_c = gate_q - GATE_W'(1);
   assign mode_run_c  = mode_is_run(mode_i);

   // Counters are zero while idle and on the edge that aborts a window.
   assign chan_clear_c = (state_q == IDLE) || (state_nxt == IDLE);

   // Gate FSM next state, gate counter and window boundary decode.
   always_comb begin
      state_nxt    = state_q;
      gate_cnt_nxt = gate_cnt_q;
      load_cfg_c   = 1'b0;
      done_c       = 1'b0;
      case (state_q)
         IDLE: begin
            gate_cnt_nxt = '0;
            if ((mode_i == MODE_CONT) || ((mode_i == MODE_SINGLE) && start_i)) begin
               state_nxt  = RUN;
               load_cfg_c = 1'b1;
            end
         end
         RUN: begin
            if (!mode_run_c) begin
               state_nxt    = IDLE;
               gate_cnt_nxt = '0;
            end else if (gate_cnt_q == gate_last_c) begin
               done_c       = 1'b1;
               load_cfg_c   = 1'b1;
               gate_cnt_nxt = '0;
               if (mode_i != MODE_CONT) begin
                  state_nxt = IDLE;
               end
            end else begin
               gate_cnt_nxt = gate_cnt_q + GATE_W'(1);
            end
         end
         default: begin
            state_nxt    = IDLE;
            gate_cnt_nxt = '0;
         end
      endcase
   end

   // State, latched window configuration and result registers.
   always_ff @(posedge slowclock) begin
      if (reset) begin
         state_q    <= IDLE;
         gate_cnt_q <= '0;
         gate_q     <= GATE_W'(GATE_MIN);
         edge_sel_q <= '0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
         freq_o     <= '0;
         ovf_o      <= '0;
      end else begin
         state_q    <= state_nxt;
         gate_cnt_q <= gate_cnt_nxt;
         if (load_cfg_c) begin
            gate_q     <= gate_eff_c;
            edge_sel_q <= edge_sel_i;
         end
         busy_o  <= (state_nxt == RUN);
         valid_o <= done_c;
         if (done_c) begin
            freq_o <= chan_count_c;
            ovf_o  <= chan_ovf_c;
         end
      end
   end

   // One measurement channel per input bit.
   for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
      freq_chan #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .slowclock (slowclock),
         .reset     (reset),
         .meas      (meas_i[n]),
         .edge_sel  (edge_sel_q[n]),
         .clear     (chan_clear_c),
         .capture   (done_c),
         .count_c   (chan_count_c[n]),
         .ovf_c     (chan_ovf_c[n])
      );
   end

endmodule

// File: tb/tb_freq_counter_multi.sv
// Randomised scoreboard bench for freq_counter_multi with a window-level model.
module tb_freq_counter_multi;
   import freq_counter_pkg::*;

   localparam int unsigned NUM_CH      = 2;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned GATE_W      = 16;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int S    = int'(SYNC_STAGES);
   localparam int MAXC = 60000;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic                    slowclock = 1'b0;
   logic                    reset;
   logic [NUM_CH-1:0]       meas_i;
   logic [1:0]              mode_i;
   logic [NUM_CH-1:0]       edge_sel_i;
   logic [GATE_W-1:0]       gate_period_i;
   logic                    start_i;
   logic                    busy_o;
   logic                    valid_o;
   logic [NUM_CH*CNT_W-1:0] freq_o;
   logic [NUM_CH-1:0]       ovf_o;

   freq_counter_multi #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .GATE_W      (GATE_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .slowclock     (slowclock),
      .reset         (reset),
      .meas_i        (meas_i),
      .mode_i        (mode_i),
      .edge_sel_i    (edge_sel_i),
      .gate_period_i (gate_period_i),
      .start_i       (start_i),
      .busy_o        (busy_o),
      .valid_o       (valid_o),
      .freq_o        (freq_o),
      .ovf_o         (ovf_o)
   );

   always #5 slowclock = ~slowclock;

   typedef struct {
      int                      cyc;
      logic [NUM_CH*CNT_W-1:0] freq;
      logic [NUM_CH-1:0]       ovf;
   } exp_t;

   exp_t sb_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   bit                exp_busy [MAXC];
   bit                clr_at   [MAXC];
   logic [NUM_CH-1:0] mh       [MAXC];

   // Stimulus shaping: hp>0 gives a square wave of half-period hp, else random toggles.
   int tp [NUM_CH];
   int hp [NUM_CH];

   // Window model state.
   bit                m_run = 1'b0;
   int                m_wstart;
   int                m_wlen;
   logic [NUM_CH-1:0] m_wsel;

   function automatic int clampg(input int gp);
      return (gp < 2) ? 2 : gp;
   endfunction

   function automatic bit is_run(input logic [1:0] md);
      return (md == 2'b01) || (md == 2'b10);
   endfunction

   // Expected result of a completed window: edges seen on the delayed input history.
   task automatic push_window(input int c);
      exp_t e;
      int   k;
      e.cyc  = c + 1;
      e.freq = '0;
      e.ovf  = '0;
      for (int n = 0; n < int'(NUM_CH); n++) begin
         k = 0;
         for (int j = m_wstart - S; j <= c - S; j++) begin
            if (m_wsel[n]) begin
               if (mh[j][n] != mh[j-1][n]) k++;
            end else if (mh[j][n] && !mh[j-1][n]) begin
               k++;
            end
         end
         if (k > CMAX) begin
            e.freq[n*CNT_W +: CNT_W] = CNT_W'(CMAX);
            e.ovf[n] = 1'b1;
         end else begin
            e.freq[n*CNT_W +: CNT_W] = CNT_W'(k);
            e.ovf[n] = 1'b0;
         end
      end
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs and advance the window model.
   task automatic step(input logic [1:0] md, input logic st, input int gp,
                       input logic [NUM_CH-1:0] es, input logic rst);
      logic [NUM_CH-1:0] m;
      @(posedge slowclock);
      cyc++;
      if (cyc >= MAXC - 2) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 2);
         $fatal(1, "cycle budget exhausted");
      end
      #1;
      m = meas_i;
      for (int n = 0; n < int'(NUM_CH); n++) begin
         if (hp[n] != 0) m[n] = ((cyc / hp[n]) % 2) != 0;
         else if (int'($urandom_range(99)) < tp[n]) m[n] = ~m[n];
      end
      meas_i        = m;
      mode_i        = md;
      start_i       = st;
      gate_period_i = GATE_W'(gp);
      edge_sel_i    = es;
      reset         = rst;
      mh[cyc]       = m;
      exp_busy[cyc] = m_run;
      if (rst) begin
         m_run = 1'b0;
         clr_at[cyc+1] = 1'b1;
      end else if (!m_run) begin
         if ((md == 2'b01) || ((md == 2'b10) && st)) begin
            m_run    = 1'b1;
            m_wstart = cyc + 1;
            m_wlen   = clampg(gp);
            m_wsel   = es;
         end
      end else if (!is_run(md)) begin
         m_run = 1'b0;
      end else if (cyc == m_wstart + m_wlen - 1) begin
         push_window(cyc);
         if (md == 2'b01) begin
            m_wstart = cyc + 1;
            m_wlen   = clampg(gp);
            m_wsel   = es;
         end else begin
            m_run = 1'b0;
         end
      end
   endtask

   task automatic run(input logic [1:0] md, input logic st, input int gp,
                      input logic [NUM_CH-1:0] es, input int ncyc);
      for (int i = 0; i < ncyc; i++) step(md, st, gp, es, 1'b0);
   endtask

   // Monitor: busy every cycle, results on valid_o, held results otherwise.
   logic [NUM_CH*CNT_W-1:0] hold_f = '0;
   logic [NUM_CH-1:0]       hold_o = '0;

   always @(negedge slowclock) begin
      exp_t e;
      if (cyc >= 1) begin
         if (clr_at[cyc]) begin
            hold_f = '0;
            hold_o = '0;
         end
         n_cmp++;
         if (busy_o !== exp_busy[cyc]) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, exp_busy[cyc]);
         end
         if ((sb_q.size() > 0) && (sb_q[0].cyc < cyc)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_valid cyc=%0d got=none exp_at=%0d", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
         end
         if (valid_o === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_valid cyc=%0d got=1 exp=0", cyc);
            end else begin
               e = sb_q.pop_front();
               if (e.cyc != cyc) begin
                  n_fail++;
                  $display("FAIL valid_cycle got=%0d exp=%0d", cyc, e.cyc);
               end
               n_cmp++;
               if (freq_o !== e.freq) begin
                  n_fail++;
                  $display("FAIL freq cyc=%0d got=%h exp=%h", cyc, freq_o, e.freq);
               end
               n_cmp++;
               if (ovf_o !== e.ovf) begin
                  n_fail++;
                  $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf_o, e.ovf);
               end
               hold_f = e.freq;
               hold_o = e.ovf;
            end
         end else begin
            n_cmp++;
            if ((valid_o !== 1'b0) || (freq_o !== hold_f) || (ovf_o !== hold_o)) begin
               n_fail++;
               $display("FAIL hold cyc=%0d got=%b/%h/%b exp=0/%h/%b",
                        cyc, valid_o, freq_o, ovf_o, hold_f, hold_o);
            end
         end
      end
   end

   initial begin
      meas_i        = '0;
      mode_i        = MODE_OFF;
      start_i       = 1'b0;
      gate_period_i = '0;
      edge_sel_i    = '0;
      reset         = 1'b1;
      mh[0]         = '0;
      for (int n = 0; n < int'(NUM_CH); n++) begin
         tp[n] = 0;
         hp[n] = 0;
      end

      // Reset, then let the synchronisers settle.
      repeat (3) step(MODE_OFF, 1'b0, 0, '0, 1'b1);
      run(MODE_OFF, 1'b0, 0, '0, 6);

      // Rate check: periods 10 and 40, rising edges then channel 0 on both edges.
      hp[0] = 5;
      hp[1] = 20;
      run(MODE_CONT, 1'b0, 1000, 2'b00, 3001);
      run(MODE_OFF, 1'b0, 1000, 2'b00, 5);
      run(MODE_CONT, 1'b0, 1000, 2'b01, 2001);
      run(MODE_OFF, 1'b0, 1000, 2'b01, 5);

      // Saturation window followed by a quiet window.
      hp[1] = 0;
      tp[1] = 30;
      run(MODE_CONT, 1'b0, 4000, 2'b00, 4001);
      hp[0] = 0;
      tp[0] = 0;
      tp[1] = 0;
      run(MODE_CONT, 1'b0, 4000, 2'b00, 4000);
      run(MODE_OFF, 1'b0, 4000, 2'b00, 5);

      // Single shot with a stray start mid-window.
      tp[0] = 20;
      tp[1] = 40;
      run(MODE_SINGLE, 1'b1, 50, 2'b00, 1);
      run(MODE_SINGLE, 1'b0, 50, 2'b00, 19);
      run(MODE_SINGLE, 1'b1, 50, 2'b00, 1);
      run(MODE_SINGLE, 1'b0, 50, 2'b00, 80);
      run(MODE_OFF, 1'b0, 50, 2'b00, 5);

      // Abort at gate count 300, results must hold.
      run(MODE_CONT, 1'b0, 1000, 2'b10, 301);
      run(MODE_OFF, 1'b0, 1000, 2'b10, 20);

      // Reset in the middle of a window after a completed one.
      run(MODE_CONT, 1'b0, 200, 2'b11, 301);
      step(MODE_CONT, 1'b0, 200, 2'b11, 1'b1);
      run(MODE_OFF, 1'b0, 200, 2'b11, 6);

      // Gate clamp for 0 and 1.
      run(MODE_CONT, 1'b0, 0, 2'b01, 11);
      run(MODE_CONT, 1'b0, 1, 2'b10, 6);
      run(MODE_OFF, 1'b0, 1, 2'b00, 5);

      // Gate change mid-window applies from the next window.
      run(MODE_CONT, 1'b0, 1000, 2'b00, 400);
      run(MODE_CONT, 1'b0, 500, 2'b00, 1601);
      run(MODE_OFF, 1'b0, 500, 2'b00, 5);

      // Continuous to single-shot mid-window: window completes, then idle.
      run(MODE_CONT, 1'b0, 100, 2'b00, 150);
      run(MODE_SINGLE, 1'b0, 100, 2'b00, 200);
      run(MODE_OFF, 1'b0, 100, 2'b00, 5);

      // Random segments of modes, starts, gates, edge selects and rates.
      for (int s = 0; s < 25; s++) begin
         int                len;
         int                gp;
         logic [1:0]        md;
         logic [NUM_CH-1:0] es;
         len = int'($urandom_range(400, 1));
         gp  = int'($urandom_range(300));
         md  = 2'($urandom_range(3));
         es  = NUM_CH'($urandom_range(3));
         for (int n = 0; n < int'(NUM_CH); n++) tp[n] = int'($urandom_range(90));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(49) == 0) gp = int'($urandom_range(300));
            if ($urandom_range(99) == 0) es = NUM_CH'($urandom_range(3));
            step(md, ($urandom_range(19) == 0), gp, es, 1'b0);
         end
         if ($urandom_range(9) == 0) begin
            step(md, 1'b0, gp, es, 1'b1);
            run(MODE_OFF, 1'b0, gp, es, 6);
         end
      end

      run(MODE_OFF, 1'b0, 0, '0, 10);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending exp=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
